// File: rtl/nes_cpu_bus_master.sv
// ---------------------------------------------------------------------------
// nes_cpu_bus_master
//
// Console-side initiator for the cartridge CPU bus. Generates a free-running
// M2 clock and, once per M2 period, one 2A03-style bus cycle. The cycle is
// either idle or carries a request taken over a valid/ready handshake.
// Mappers count M2 edges, so M2 runs continuously and idle cycles are
// emitted whenever no request is pending.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   req_valid      request pending
//   req_ready      high on the last M2-high tick; handshake latches req_*
//   req_rw         1 = read, 0 = write
//   req_addr       16-bit CPU address (A15 selects /ROMSEL)
//   req_wdata      write data
//   resp_valid     one-tick pulse at the M2 fall ending a non-idle cycle
//   resp_rdata     bus value sampled on the last M2-high tick
//   m2             M2 clock
//   romsel         /ROMSEL, active low
//   cpu_rw         R/W
//   cpu_addr       A14..A0
//   cpu_data_out   data driven onto the bus during writes
//   cpu_data_oe    drive enable for cpu_data_out
//   cpu_data_in    bus data as seen by the console
//   cycle_count    completed M2 cycles (falling edges), wraps
// ---------------------------------------------------------------------------
module nes_cpu_bus_master #(
  parameter int M2_LOW_TICKS  = 5,
  parameter int M2_HIGH_TICKS = 7,
  parameter int ROMSEL_DELAY  = 1,
  parameter int WDATA_DELAY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in,
  output logic [31:0] cycle_count
);

  localparam int CNT_MAX = (M2_LOW_TICKS > M2_HIGH_TICKS) ? M2_LOW_TICKS : M2_HIGH_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] LOW_LAST    = CNT_W'(M2_LOW_TICKS - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST   = CNT_W'(M2_HIGH_TICKS - 1);
  localparam logic [CNT_W-1:0] ROMSEL_TICK = CNT_W'(ROMSEL_DELAY);
  localparam logic [CNT_W-1:0] WDATA_TICK  = CNT_W'(WDATA_DELAY);

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_e;

  // Phase machine
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bus cycle currently on the pins (loaded at M2 fall)
  logic             act_q, act_d;     // non-idle cycle
  logic             a15_q, a15_d;     // A15, not a pin: it only gates /ROMSEL
  logic [7:0]       wdata_q, wdata_d;

  // Registered outputs
  logic             m2_q, m2_d;
  logic             romsel_q, romsel_d;
  logic             cpu_rw_q, cpu_rw_d;
  logic [14:0]      cpu_addr_q, cpu_addr_d;
  logic [7:0]       cpu_data_out_q, cpu_data_out_d;
  logic             cpu_data_oe_q, cpu_data_oe_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [7:0]       resp_rdata_q, resp_rdata_d;
  logic [31:0]      cycle_count_q, cycle_count_d;

  logic last_low, last_high, handshake, write_cyc;

  assign last_low  = (phase_q == PH_LOW)  && (cnt_q == LOW_LAST);
  assign last_high = (phase_q == PH_HIGH) && (cnt_q == HIGH_LAST);
  assign handshake = last_high && req_valid && req_ready_q;
  assign write_cyc = act_q && !cpu_rw_q;

  // Every _d describes the tick that starts at the next clock edge, so the
  // registered outputs line up exactly with the phase/counter position.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    phase_d        = phase_q;
    cnt_d          = cnt_q + CNT_W'(1);
    act_d          = act_q;
    a15_d          = a15_q;
    wdata_d        = wdata_q;
    romsel_d       = romsel_q;
    cpu_rw_d       = cpu_rw_q;
    cpu_addr_d     = cpu_addr_q;
    cpu_data_out_d = cpu_data_out_q;
    cpu_data_oe_d  = cpu_data_oe_q;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = resp_rdata_q;
    cycle_count_d  = cycle_count_q;

    if (last_low) begin
      phase_d = PH_HIGH;
      cnt_d   = '0;
    end else if (last_high) begin
      phase_d = PH_LOW;
      cnt_d   = '0;
    end

    m2_d        = (phase_d == PH_HIGH);
    req_ready_d = (phase_d == PH_HIGH) && (cnt_d == HIGH_LAST);

    if (last_high) begin
      // M2 fall: close out the finishing cycle and open the next one.
      resp_valid_d  = act_q;
      if (act_q) begin
        resp_rdata_d = cpu_data_in;
      end
      cycle_count_d = cycle_count_q + 32'd1;

      act_d      = handshake;
      a15_d      = handshake && req_addr[15];
      cpu_rw_d   = handshake ? req_rw : 1'b1;
      cpu_addr_d = handshake ? req_addr[14:0] : 15'h0000;
      if (handshake) begin
        wdata_d = req_wdata;
      end
      romsel_d = 1'b1;
      // Write data deliberately stays on the bus through LOW tick 0 (hold).
    end else if (phase_d == PH_HIGH) begin
      romsel_d      = !(act_q && a15_q && (cnt_d >= ROMSEL_TICK));
      cpu_data_oe_d = write_cyc && (cnt_d >= WDATA_TICK);
      if (write_cyc && (cnt_d == WDATA_TICK)) begin
        cpu_data_out_d = wdata_q;
      end
    end else begin
      // LOW ticks after the fall: bus released, /ROMSEL idle.
      romsel_d      = 1'b1;
      cpu_data_oe_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q        <= PH_LOW;
      cnt_q          <= '0;
      act_q          <= 1'b0;
      a15_q          <= 1'b0;
      wdata_q        <= 8'h00;
      m2_q           <= 1'b0;
      romsel_q       <= 1'b1;
      cpu_rw_q       <= 1'b1;
      cpu_addr_q     <= 15'h0000;
      cpu_data_out_q <= 8'h00;
      cpu_data_oe_q  <= 1'b0;
      req_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= 8'h00;
      cycle_count_q  <= 32'h0000_0000;
    end else begin
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      act_q          <= act_d;
      a15_q          <= a15_d;
      wdata_q        <= wdata_d;
      m2_q           <= m2_d;
      romsel_q       <= romsel_d;
      cpu_rw_q       <= cpu_rw_d;
      cpu_addr_q     <= cpu_addr_d;
      cpu_data_out_q <= cpu_data_out_d;
      cpu_data_oe_q  <= cpu_data_oe_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      cycle_count_q  <= cycle_count_d;
    end
  end

  assign m2           = m2_q;
  assign romsel       = romsel_q;
  assign cpu_rw       = cpu_rw_q;
  assign cpu_addr     = cpu_addr_q;
  assign cpu_data_out = cpu_data_out_q;
  assign cpu_data_oe  = cpu_data_oe_q;
  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_nes_cpu_bus_master.sv
// ---------------------------------------------------------------------------
// tb_nes_cpu_bus_master
//
// Bench for nes_cpu_bus_master at default parameters (5 low / 7 high ticks,
// /ROMSEL and write data from HIGH tick 1). The expected bus is derived from
// an absolute tick number t since reset release: t/12 is the M2 cycle and
// t%12 the position in it (0..4 low, 5..11 high). A per-cycle table of
// accepted requests gives what each cycle must carry. A simple cart model
// answers reads.
// ---------------------------------------------------------------------------
module tb_nes_cpu_bus_master;

  localparam int PERIOD = 12;
  localparam int NCYC   = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_rw = 1'b1;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        req_ready;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        m2;
  logic        romsel;
  logic        cpu_rw;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic [7:0]  cpu_data_in;
  logic [31:0] cycle_count;

  // Cart side: /ROMSEL low selects PRG space, otherwise only 0x4017 answers.
  function automatic logic [7:0] cart_byte(input logic sel_n, input logic [14:0] a);
    if (!sel_n) begin
      if (a == 15'h0123)      return 8'h5A;
      else if (a == 15'h4000) return 8'hC3;
      else                    return 8'hFF;
    end
    return (a == 15'h4017) ? 8'h17 : 8'hFF;
  endfunction

  // What a read of a full CPU address must return from that cart.
  function automatic logic [7:0] ref_read(input logic [15:0] a);
    case (a)
      16'h8123: return 8'h5A;
      16'hC000: return 8'hC3;
      16'h4017: return 8'h17;
      default:  return 8'hFF;
    endcase
  endfunction

  assign cpu_data_in = cpu_data_oe ? cpu_data_out : cart_byte(romsel, cpu_addr);

  nes_cpu_bus_master dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rw       (req_rw),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .m2           (m2),
    .romsel       (romsel),
    .cpu_rw       (cpu_rw),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_data_oe  (cpu_data_oe),
    .cpu_data_in  (cpu_data_in),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  // Tick number since reset release.
  int t = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  // Model state: which cycles carry a request, and cycle_count offset.
  logic        m_act  [NCYC];
  logic        m_rw   [NCYC];
  logic [15:0] m_addr [NCYC];
  logic [7:0]  m_wd   [NCYC];
  logic [31:0] cc_base = 32'h0;
  int          c_base  = 0;

  // Tick markers for the hand-computed expectations (written by stimulus only).
  int lit_idle = -1000;
  int lit_rd   = -1000;
  int lit_wr   = -1000;
  int lit_post = -1000;
  int lit_wrap = -1000;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d actual=%h expected=%h", name, t, act, exp);
    end
  endtask

  int          mc, mp, mcp;
  logic        cur, prev, e_oe;
  logic [7:0]  e_rd;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCYC; i++) begin
        m_act[i]  = 1'b0;
        m_rw[i]   = 1'b1;
        m_addr[i] = 16'h0000;
        m_wd[i]   = 8'h00;
      end
      check("rst_m2",      32'(m2),           32'd0);
      check("rst_romsel",  32'(romsel),       32'd1);
      check("rst_cpu_rw",  32'(cpu_rw),       32'd1);
      check("rst_addr",    32'(cpu_addr),     32'd0);
      check("rst_dout",    32'(cpu_data_out), 32'd0);
      check("rst_oe",      32'(cpu_data_oe),  32'd0);
      check("rst_ready",   32'(req_ready),    32'd0);
      check("rst_rvalid",  32'(resp_valid),   32'd0);
      check("rst_rdata",   32'(resp_rdata),   32'd0);
      check("rst_cc",      cycle_count,       32'd0);
    end else if (t < (NCYC - 1) * PERIOD) begin
      mc   = t / PERIOD;
      mp   = t % PERIOD;
      mcp  = (mc > 0) ? mc - 1 : 0;
      cur  = m_act[mc];
      prev = (mc > 0) && m_act[mcp];

      check("m2",        32'(m2),        32'(mp >= 5));
      check("req_ready", 32'(req_ready), 32'(mp == 11));
      check("cpu_addr",  32'(cpu_addr),  cur ? 32'(m_addr[mc][14:0]) : 32'd0);
      check("cpu_rw",    32'(cpu_rw),    cur ? 32'(m_rw[mc]) : 32'd1);
      check("romsel",    32'(romsel),    32'(!(cur && m_addr[mc][15] && mp >= 6)));
      e_oe = (cur && !m_rw[mc] && mp >= 6) || (mp == 0 && prev && !m_rw[mcp]);
      check("data_oe",   32'(cpu_data_oe), 32'(e_oe));
      if (e_oe)
        check("data_out", 32'(cpu_data_out), (mp == 0) ? 32'(m_wd[mcp]) : 32'(m_wd[mc]));
      check("resp_valid", 32'(resp_valid), 32'(mp == 0 && prev));
      if (mp == 0 && prev) begin
        e_rd = m_rw[mcp] ? ref_read(m_addr[mcp]) : m_wd[mcp];
        check("resp_rdata", 32'(resp_rdata), 32'(e_rd));
      end
      check("cycle_count", cycle_count, cc_base + 32'(mc - c_base));

      // Hand-computed expectations pinning the model.
      if (t == lit_idle) begin
        check("lit_idle_cc", cycle_count, 32'd10);
        check("lit_idle_m2", 32'(m2), 32'd0);
      end
      if (t == lit_rd + 1) begin
        check("lit_rd_addr", 32'(cpu_addr), 32'h0000_0123);
        check("lit_rd_rw",   32'(cpu_rw),   32'd1);
      end
      if (t == lit_rd + 6)  check("lit_rd_sel_h0", 32'(romsel), 32'd1);
      if (t == lit_rd + 7)  check("lit_rd_sel_h1", 32'(romsel), 32'd0);
      if (t == lit_rd + 12) begin
        check("lit_rd_sel_h6", 32'(romsel),     32'd0);
        check("lit_rd_rv_pre", 32'(resp_valid), 32'd0);
      end
      if (t == lit_rd + 13) begin
        check("lit_rd_rv",    32'(resp_valid), 32'd1);
        check("lit_rd_rdata", 32'(resp_rdata), 32'h0000_005A);
      end
      if (t == lit_wr + 1) begin
        check("lit_wr_addr", 32'(cpu_addr), 32'h0000_6000);
        check("lit_wr_rw",   32'(cpu_rw),   32'd0);
      end
      if (t == lit_wr + 6) check("lit_wr_oe_h0", 32'(cpu_data_oe), 32'd0);
      if (t == lit_wr + 7) begin
        check("lit_wr_oe_h1", 32'(cpu_data_oe),  32'd1);
        check("lit_wr_data",  32'(cpu_data_out), 32'h0000_00A5);
        check("lit_wr_sel",   32'(romsel),       32'd1);
      end
      if (t == lit_wr + 13) begin
        check("lit_wr_oe_hold", 32'(cpu_data_oe), 32'd1);
        check("lit_wr_rv",      32'(resp_valid),  32'd1);
      end
      if (t == lit_wr + 14) check("lit_wr_oe_off", 32'(cpu_data_oe), 32'd0);
      if (t == lit_post) begin
        check("lit_post_rv", 32'(resp_valid), 32'd0);
        check("lit_post_cc", cycle_count,     32'd1);
      end
      if (t == lit_wrap) check("lit_wrap_cc", cycle_count, 32'h0000_0001);

      // Handshake on the last HIGH tick fills the next cycle.
      if (mp == 11 && req_valid && mc + 1 < NCYC) begin
        m_act[mc+1]  = 1'b1;
        m_rw[mc+1]   = req_rw;
        m_addr[mc+1] = req_addr;
        m_wd[mc+1]   = req_wdata;
      end
    end
  end

  // Drive one request, held on exactly one handshake slot; returns that tick.
  task automatic do_req(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                        output int hs);
    int n;
    n = 0;
    @(posedge clk); #2;
    while (t % PERIOD != 11) begin
      @(posedge clk); #2;
      n++;
      if (n > 3 * PERIOD) begin
        $display("FAIL do_req slot wait t=%0d", t);
        $fatal(1, "no handshake slot");
      end
    end
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk); #2;
    hs        = t - 1;
    req_valid = 1'b0;
    req_rw    = ~rw;
    req_addr  = 16'hFFFF;
    req_wdata = 8'h00;
  endtask

  // Return at the negedge (sample point) of tick number target.
  task automatic wait_tick(input int target);
    int n;
    n = 0;
    while (t < target) begin
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        $display("FAIL wait_tick t=%0d target=%0d", t, target);
        $fatal(1, "tick wait expired");
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int hs;
    #400_000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle M2 cycles only.
    lit_idle = 10 * PERIOD;
    wait_tick(125);

    // Read from PRG space, then a write to PRG-RAM space back to back.
    do_req(1'b1, 16'h8123, 8'h00, hs);
    lit_rd = hs;
    do_req(1'b0, 16'h6000, 8'hA5, hs);
    lit_wr = hs;

    // req_valid pulse that never sees a ready tick: no cycle.
    repeat (4) @(posedge clk);
    #2;
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h8123;
    repeat (3) @(posedge clk);
    #2;
    req_valid = 1'b0;

    // Three back-to-back requests.
    do_req(1'b0, 16'h8000, 8'h80, hs);
    do_req(1'b1, 16'hC000, 8'h00, hs);
    do_req(1'b1, 16'h4017, 8'h00, hs);

    // Reset in the middle of a write's HIGH phase.
    do_req(1'b0, 16'hE000, 8'h3C, hs);
    wait_tick(hs + 9);
    #1;
    rst_n    = 1'b0;
    lit_idle = -1000;
    lit_rd   = -1000;
    lit_wr   = -1000;
    cc_base  = 32'h0;
    c_base   = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    lit_post = 13;
    wait_tick(30);

    // cycle_count wrap.
    #1;
    force dut.cycle_count_q = 32'hFFFF_FFFE;
    cc_base  = 32'hFFFF_FFFE;
    c_base   = t / PERIOD;
    lit_wrap = (t / PERIOD + 3) * PERIOD;
    #1;
    release dut.cycle_count_q;
    wait_tick(lit_wrap + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nes_cpu_bus_master.md
Name: nes_cpu_bus_master

Overview:
- Console-side initiator for the cartridge CPU bus. It generates the free-running M2 clock, /ROMSEL, R/W, address and data phases of a 2A03 bus cycle.
- It turns a simple request/response handshake into bus cycles. It is used as the console model in cart bring-up and dumper builds, and drives the same pins the cartridge top consumes (m2, romsel, cpu_rw_in, cpu_addr_in, cpu_data_in).
- M2 never stops. Mapper logic counts M2 edges, so idle cycles are always emitted.

Parameters:
- M2_LOW_TICKS, 5, clk ticks per M2 low phase (>=2).
- M2_HIGH_TICKS, 7, clk ticks per M2 high phase (>=3).
- ROMSEL_DELAY, 1, tick index within the high phase at which /ROMSEL asserts (< M2_HIGH_TICKS-1).
- WDATA_DELAY, 1, tick index within the high phase at which write data is driven (< M2_HIGH_TICKS-1).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request pending.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_rw  in  1  1=read, 0=write.
- req_addr  in  16  CPU address.
- req_wdata  in  8  write data.
- resp_valid  out  1  one-tick pulse on bus-cycle completion.
- resp_rdata  out  8  bus value sampled at end of M2 high.
- m2  out  1  M2 clock.
- romsel  out  1  /ROMSEL, active low.
- cpu_rw  out  1  R/W.
- cpu_addr  out  15  A14..A0.
- cpu_data_out  out  8  driven data.
- cpu_data_oe  out  1  data bus drive enable.
- cpu_data_in  in  8  bus data.
- cycle_count  out  32  completed M2 cycles, wraps.

Behaviour:
- Reset values (asynchronous on rst_n=0): m2=0, romsel=1, cpu_rw=1, cpu_addr=0, cpu_data_out=0, cpu_data_oe=0, req_ready=0, resp_valid=0, resp_rdata=0, cycle_count=0. Phase is LOW and tick counter is 0. Any latched request is discarded with no response.
- All outputs are registered.
- Phase machine:
  - LOW: m2=0, counter runs 0..M2_LOW_TICKS-1, then goes to HIGH.
  - HIGH: m2=1, counter runs 0..M2_HIGH_TICKS-1, then goes to LOW.
  - Period is M2_LOW_TICKS+M2_HIGH_TICKS ticks (12 at defaults).
- req_ready=1 only on the last HIGH tick. A handshake on that tick latches rw/addr/wdata for the next cycle. With no handshake, the next cycle is idle.
- LOW tick 0 (M2 falling):
  - Latched request: cpu_addr=addr[14:0], cpu_rw=rw.
  - Idle: address 0x0000, rw=1, no response.
  - The address-cycle register holds A15 internally.
- romsel:
  - 0 from HIGH tick ROMSEL_DELAY through the last HIGH tick, only when the cycle is non-idle and A15=1.
  - 1 otherwise.
  - romsel is 1 for the whole LOW phase.
- Write cycles:
  - cpu_data_out=wdata and cpu_data_oe=1 from HIGH tick WDATA_DELAY through LOW tick 0 of the following cycle inclusive (one-tick hold).
  - cpu_data_oe=0 on LOW tick 1.
- Read cycles: cpu_data_oe stays 0. cpu_data_in is sampled on the last HIGH tick.
- Response:
  - resp_valid pulses one tick, coinciding with LOW tick 0 of the next cycle, for every non-idle cycle.
  - resp_rdata = sampled cpu_data_in; for writes this is the bus value, normally the own data.
- Latency: handshake at tick T gives M2 fall at T+1 and resp_valid at T+M2_LOW_TICKS+M2_HIGH_TICKS+1.
- Back-to-back requests run at full M2 rate with no idle cycle between them.
- cycle_count increments on every M2 falling edge, idle or not, and wraps 0xFFFFFFFF→0.
- Reset release: the first handshake opportunity is at the end of the first HIGH phase. The first cycle is always idle.
- req_valid dropping without a handshake has no effect. req_* are only sampled on the handshake tick.

Test Plan:
- Reset, then run 120 ticks with req_valid=0. m2 has period 12 (5 low/7 high), romsel stays 1, cpu_data_oe=0, no resp_valid, cycle_count=10.
- Read 0x8123, with cart model returning 0x5A. cpu_addr=0x0123, rw=1, romsel=0 on HIGH ticks 1-6, resp_valid 13 ticks after handshake, resp_rdata=0x5A.
- Write 0x6000←0xA5. romsel stays 1, cpu_rw=0, cpu_data_oe=1 from HIGH tick 1 through next LOW tick 0, data 0xA5, resp_valid pulse.
- Three back-to-back requests (write 0x8000←0x80, read 0xC000, read 0x4017). Three consecutive bus cycles, no idle gap, romsel low only on the first two, three resp_valid pulses 12 ticks apart.
- Assert rst_n=0 mid-HIGH of a write. All outputs take reset values immediately, no resp_valid afterwards, the next cycle is idle.
- Preload cycle_count near wrap (force 0xFFFFFFFE), run 3 cycles. The count reads 0x00000001.
